// File: rtl/pwm_pkg.sv
// Shared definitions for the breathing-LED envelope generator: FSM state
// encodings, the default PWM period, and the common "fade one step" rule.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_t;

  // Constant period handed to the downstream 8-bit PWM.
  localparam logic [7:0] PERIOD_DEFAULT = 8'd254;

  // Result of one downward step of the envelope.
  typedef struct packed {
    state_t     state;
    logic [7:0] duty;
  } fall_step_t;

  // One FALL tick: decrement while above zero, otherwise move on to the low
  // dwell. Also used when a stop request cuts a rise or peak dwell short, so
  // the envelope leaves the peak side without any jump in duty.
  function automatic fall_step_t fall_step(input logic [7:0] duty);
    fall_step_t r;
    if (duty == 8'd0) begin
      r.state = ST_HOLD_LO;
      r.duty  = 8'd0;
    end else begin
      r.state = ST_FALL;
      r.duty  = duty - 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_breath_tick_div.sv
// Step divider: produces a one-cycle tick every (div+1) clocks. Held at zero
// while clr is high so the first tick after a start lands div+1 clocks later.
module tick_div
  #(
    parameter int unsigned DIV_W = 24
  ) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
  );

  logic [DIV_W-1:0] div_cnt_r;
  logic             wrap_s;

  // A divisor lowered below the running count restarts the count instead of
  // letting it run all the way round the counter width.
  assign wrap_s = (div_cnt_r >= div);
  assign tick   = (!clr) && (div_cnt_r == div);

  // Divider count: 0..div then back to 0, parked at 0 while cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (wrap_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pwm_breath.sv
// Breathing envelope generator: ramps a PWM duty from 0 up to a latched peak,
// dwells, ramps back to 0 and dwells again, one step per divider tick.
// Dropping en finishes the current breath gracefully on the falling side.
module pwm_breath
  import pwm_pkg::*;
  #(
    parameter logic [7:0]  PERIOD = PERIOD_DEFAULT,
    parameter int unsigned DIV_W  = 24
  ) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] step_div,
    input  logic [7:0]       max_duty,
    input  logic [7:0]       hold_steps,
    output logic [7:0]       duty,
    output logic [7:0]       period,
    output logic             busy,
    output logic             cycle_done
  );

  state_t     state_r;
  logic [7:0] duty_r;
  logic [7:0] hold_cnt_r;
  logic [7:0] max_q_r;
  logic [7:0] hold_q_r;
  logic       busy_r;
  logic       cycle_done_r;
  logic       tick_s;
  logic       clr_s;
  fall_step_t fade_s;

  // The divider only runs while a breath is in progress.
  assign clr_s  = (state_r == ST_IDLE);
  assign fade_s = fall_step(duty_r);

  tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .div  (step_div),
    .tick (tick_s)
  );

  // Envelope sequencer: advances one step per tick; shape is latched only at
  // breath start so mid-breath input changes wait for the next breath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      duty_r       <= 8'd0;
      hold_cnt_r   <= 8'd0;
      max_q_r      <= 8'd0;
      hold_q_r     <= 8'd0;
      busy_r       <= 1'b0;
      cycle_done_r <= 1'b0;
    end else begin
      cycle_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          duty_r     <= 8'd0;
          hold_cnt_r <= 8'd0;
          if (en) begin
            max_q_r  <= max_duty;
            hold_q_r <= hold_steps;
            state_r  <= ST_RISE;
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end

        ST_RISE: begin
          if (tick_s) begin
            if (!en) begin
              // Stop request: this tick already behaves as a falling step.
              state_r    <= fade_s.state;
              duty_r     <= fade_s.duty;
              hold_cnt_r <= 8'd0;
            end else if (duty_r >= max_q_r) begin
              duty_r     <= max_q_r;
              hold_cnt_r <= 8'd0;
              state_r    <= ST_HOLD_HI;
            end else begin
              duty_r     <= duty_r + 8'd1;
            end
          end
        end

        ST_HOLD_HI: begin
          if (tick_s) begin
            if (!en) begin
              state_r    <= fade_s.state;
              duty_r     <= fade_s.duty;
              hold_cnt_r <= 8'd0;
            end else if (hold_cnt_r == hold_q_r) begin
              state_r    <= ST_FALL;
            end else begin
              hold_cnt_r <= hold_cnt_r + 8'd1;
            end
          end
        end

        ST_FALL: begin
          if (tick_s) begin
            state_r    <= fade_s.state;
            duty_r     <= fade_s.duty;
            hold_cnt_r <= 8'd0;
          end
        end

        ST_HOLD_LO: begin
          if (tick_s) begin
            if (hold_cnt_r == hold_q_r) begin
              cycle_done_r <= 1'b1;
              hold_cnt_r   <= 8'd0;
              if (en) begin
                max_q_r  <= max_duty;
                hold_q_r <= hold_steps;
                state_r  <= ST_RISE;
                busy_r   <= 1'b1;
              end else begin
                state_r  <= ST_IDLE;
                busy_r   <= 1'b0;
              end
            end else begin
              hold_cnt_r <= hold_cnt_r + 8'd1;
            end
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          duty_r     <= 8'd0;
          hold_cnt_r <= 8'd0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign duty       = duty_r;
  assign busy       = busy_r;
  assign cycle_done = cycle_done_r;
  assign period     = PERIOD;

endmodule

// File: tb/tb_pwm_breath.sv
// Bench for pwm_breath: a per-breath duty schedule model (a queue of the duty
// value each tick must produce) checked against the DUT every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_pwm_breath;

  localparam int         DIV_W  = 24;
  localparam logic [7:0] PERIOD = 8'd254;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] step_div = 24'd0;
  logic [7:0]       max_duty = 8'd0;
  logic [7:0]       hold_steps = 8'd0;
  logic [7:0]       duty;
  logic [7:0]       period;
  logic             busy;
  logic             cycle_done;

  pwm_breath #(
    .PERIOD (PERIOD),
    .DIV_W  (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .step_div   (step_div),
    .max_duty   (max_duty),
    .hold_steps (hold_steps),
    .duty       (duty),
    .period     (period),
    .busy       (busy),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  bit m_run = 1'b0;
  bit m_dropped = 1'b0;
  int m_cyc = 0;
  int m_k = 0;
  int m_m = 0;
  int m_h = 0;
  int m_q[$];
  int e_duty = 0;
  bit e_busy = 1'b0;
  bit e_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Build the whole duty schedule of one breath: value after each tick.
  task automatic m_start();
    m_m = int'(max_duty);
    m_h = int'(hold_steps);
    m_q.delete();
    m_k = 0;
    m_dropped = 1'b0;
    m_run = 1'b1;
    for (int i = 1; i <= m_m; i++) m_q.push_back(i);
    for (int i = 0; i < m_h + 2; i++) m_q.push_back(m_m);
    for (int i = m_m - 1; i >= 0; i--) m_q.push_back(i);
    for (int i = 0; i < m_h + 2; i++) m_q.push_back(0);
  endtask

  // Reference model, advanced on every clock edge and on reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_run = 1'b0;
        m_q.delete();
        e_duty = 0;
        e_busy = 1'b0;
        e_done = 1'b0;
      end else begin
        e_done = 1'b0;
        if (!m_run) begin
          e_duty = 0;
          if (en) begin
            m_start();
            m_cyc = 0;
          end
        end else begin
          if ((m_cyc % (int'(step_div) + 1)) == int'(step_div)) begin
            if (!en && !m_dropped && (m_k < m_m + m_h + 2)) begin
              m_q.delete();
              for (int d = e_duty - 1; d >= 0; d--) m_q.push_back(d);
              for (int i = 0; i < m_h + 2; i++) m_q.push_back(0);
              m_dropped = 1'b1;
            end
            e_duty = m_q.pop_front();
            m_k++;
            if (m_q.size() == 0) begin
              e_done = 1'b1;
              if (en) m_start();
              else m_run = 1'b0;
            end
          end
          m_cyc++;
        end
        e_busy = m_run;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("duty", int'(duty), e_duty);
      check("busy", int'(busy), int'(e_busy));
      check("cycle_done", int'(cycle_done), int'(e_done));
      check("period", int'(period), int'(PERIOD));
    end
  end

  task automatic set_in(input bit e, input int sd, input int md, input int hs);
    en = e;
    step_div = sd[DIV_W-1:0];
    max_duty = md[7:0];
    hold_steps = hs[7:0];
  endtask

  task automatic go_idle();
    int t;
    t = 0;
    @(negedge clk);
    #1 en = 1'b0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("reach_idle", int'(busy), 0);
  endtask

  // Gap in clocks between two cycle_done pulses, peak duty and busy drop in between.
  task automatic gap_done(input int budget, output int gap, output int peak, output bit busy_low);
    int t;
    t = 0;
    gap = -1;
    peak = 0;
    busy_low = 1'b0;
    while (t < budget) begin
      @(negedge clk);
      t++;
      if (cycle_done) break;
    end
    if (cycle_done) begin
      for (int c = 1; c <= budget; c++) begin
        @(negedge clk);
        if (int'(duty) > peak) peak = int'(duty);
        if (!busy) busy_low = 1'b1;
        if (cycle_done) begin
          gap = c;
          break;
        end
      end
    end
  endtask

  task automatic wait_duty(input int val, input int budget);
    int t;
    t = 0;
    while (int'(duty) != val && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    int exp034[12] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1};
    int g;
    int pk;
    bit bl;
    int t;
    int pulses;
    int sd;
    int md;
    int hs;
    int len;

    #1 rst = 1'b1;
    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(cycle_done), 0);
    check("rst_period", int'(period), 254);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // step 0, peak 3, no dwell: literal duty trace and 10-clock breath
    set_in(1'b1, 0, 3, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("trace034_%0d", i), int'(duty), exp034[i]);
    end
    gap_done(100, g, pk, bl);
    check("gap034", g, 10);
    go_idle();

    // step 4, peak 2, dwell 1: 50-clock breath, busy throughout
    @(negedge clk);
    #1 set_in(1'b1, 4, 2, 1);
    gap_done(200, g, pk, bl);
    check("gap035", g, 50);
    check("peak035", pk, 2);
    check("busy035", int'(bl), 0);
    go_idle();

    // zero peak, dwell 2: duty pinned at 0, 8-clock breath
    @(negedge clk);
    #1 set_in(1'b1, 0, 0, 2);
    gap_done(100, g, pk, bl);
    check("gap038", g, 8);
    check("peak038", pk, 0);
    go_idle();

    // stop request during rise at duty 5
    @(negedge clk);
    #1 set_in(1'b1, 1, 10, 1);
    wait_duty(5, 200);
    check("reach5", int'(duty), 5);
    #1 en = 1'b0;
    t = 0;
    while (int'(duty) == 5 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drop_next", int'(duty), 4);
    pulses = 0;
    t = 0;
    while (t < 300) begin
      @(negedge clk);
      t++;
      if (cycle_done) pulses++;
      if (!busy) break;
    end
    check("drop_pulses", pulses, 1);
    check("drop_idle", int'(busy), 0);

    // peak raised mid-rise applies only to the next breath
    @(negedge clk);
    #1 set_in(1'b1, 0, 3, 0);
    repeat (2) @(negedge clk);
    #1 max_duty = 8'd200;
    pk = 0;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      t++;
      if (int'(duty) > pk) pk = int'(duty);
      if (cycle_done) break;
    end
    check("peak037a", pk, 3);
    pk = 0;
    t = 0;
    while (t < 1000) begin
      @(negedge clk);
      t++;
      if (int'(duty) > pk) pk = int'(duty);
      if (cycle_done) break;
    end
    check("peak037b", pk, 200);
    go_idle();

    // asynchronous reset during peak dwell at duty 7
    @(negedge clk);
    #1 set_in(1'b1, 1, 7, 5);
    wait_duty(7, 200);
    repeat (4) @(negedge clk);
    check("hold_hi7", int'(duty), 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_duty", int'(duty), 0);
    check("async_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_duty(1, 20);
    check("restart_duty", int'(duty), 1);
    check("restart_busy", int'(busy), 1);

    // randomized segments, checked cycle by cycle against the model
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
      end else begin
        go_idle();
      end
      sd = int'($urandom_range(0, 3));
      md = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 20));
      hs = int'($urandom_range(0, 4));
      @(negedge clk);
      #1 set_in(1'b1, sd, md, hs);
      len = int'($urandom_range(20, 300));
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        #1;
        if ($urandom_range(0, 29) == 0) en = ~en;
        if ($urandom_range(0, 39) == 0) max_duty = 8'($urandom_range(0, 30));
        if ($urandom_range(0, 39) == 0) hold_steps = 8'($urandom_range(0, 4));
      end
    end
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
